// File: rtl/mem_responder.sv
// mem_responder: target side of the CPU rd/wr strobe bus. Serves requests from
// an internal store with programmable wait states, write protection and an access counter.
module mem_responder #(
   parameter int AWIDTH      = 5,
   parameter int DWIDTH      = 8,
   parameter int WAIT_STATES = 2,
   parameter int PROT_BASE   = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd,
   input  logic              wr,
   input  logic [AWIDTH-1:0] addr,
   input  logic [DWIDTH-1:0] wdata,
   output logic [DWIDTH-1:0] rdata,
   output logic              rdata_en,
   output logic              ready,
   output logic              err,
   output logic              busy,
   output logic [15:0]       acc_cnt
);
   typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

   localparam logic [3:0]  WS       = 4'(WAIT_STATES);
   localparam logic [31:0] PROT_LIM = 32'(PROT_BASE);
   localparam int          DEPTH    = 2**AWIDTH;

   state_t            state_reg;
   logic [3:0]        wait_cnt_reg;
   logic [AWIDTH-1:0] addr_reg;
   logic [DWIDTH-1:0] wdata_reg;
   logic              rd_reg;
   logic              wr_reg;
   logic              ready_reg;
   logic              err_reg;
   logic              rdata_en_reg;
   logic              busy_reg;
   logic [15:0]       acc_cnt_reg;
   logic [DWIDTH-1:0] mem_rdata_reg;
   logic [DWIDTH-1:0] mem [DEPTH];

   logic              cap_rd;
   logic              cap_wr;
   logic [AWIDTH-1:0] cap_addr;
   logic              cap_prot;
   logic              ack_err;
   logic              ack_read;
   logic              commit;

   // In IDLE the live bus is the request (zero-wait path straight to ACK);
   // afterwards only the latched copy matters, so late bus changes are ignored.
   always_comb begin
      cap_rd   = rd_reg;
      cap_wr   = wr_reg;
      cap_addr = addr_reg;
      if (state_reg == IDLE) begin
         cap_rd   = rd;
         cap_wr   = wr;
         cap_addr = addr;
      end
   end

   assign cap_prot = 32'(cap_addr) >= PROT_LIM;
   assign ack_err  = (cap_rd & cap_wr) | (cap_wr & cap_prot);
   assign ack_read = cap_rd & ~cap_wr;
   assign commit   = (state_reg == ACK) & cap_wr & ~cap_rd & ~cap_prot;

   // Store is never reset; the read register tracks the address the next ACK will use.
   always_ff @(posedge clk) begin
      if (commit)
         mem[addr_reg] <= wdata_reg;
      mem_rdata_reg <= mem[cap_addr];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         wait_cnt_reg <= '0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         rd_reg       <= 1'b0;
         wr_reg       <= 1'b0;
         ready_reg    <= 1'b0;
         err_reg      <= 1'b0;
         rdata_en_reg <= 1'b0;
         busy_reg     <= 1'b0;
         acc_cnt_reg  <= '0;
      end else begin
         ready_reg    <= 1'b0;
         err_reg      <= 1'b0;
         rdata_en_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (rd || wr) begin
                  addr_reg     <= addr;
                  wdata_reg    <= wdata;
                  rd_reg       <= rd;
                  wr_reg       <= wr;
                  wait_cnt_reg <= WS;
                  busy_reg     <= 1'b1;
                  if (WS == 4'd0) begin
                     state_reg    <= ACK;
                     ready_reg    <= 1'b1;
                     err_reg      <= ack_err;
                     rdata_en_reg <= ack_read;
                  end else begin
                     state_reg <= WAIT;
                  end
               end
            end
            WAIT: begin
               wait_cnt_reg <= wait_cnt_reg - 4'd1;
               if (wait_cnt_reg == 4'd1) begin
                  state_reg    <= ACK;
                  ready_reg    <= 1'b1;
                  err_reg      <= ack_err;
                  rdata_en_reg <= ack_read;
               end
            end
            ACK: begin
               state_reg <= HOLD;
               if (acc_cnt_reg != 16'hFFFF)
                  acc_cnt_reg <= acc_cnt_reg + 16'd1;
            end
            HOLD: begin
               if (!rd && !wr) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign rdata    = rdata_en_reg ? mem_rdata_reg : '0;
   assign rdata_en = rdata_en_reg;
   assign ready    = ready_reg;
   assign err      = err_reg;
   assign busy     = busy_reg;
   assign acc_cnt  = acc_cnt_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and one
// with none (used for the zero-latency and counter saturation scenario).
module tb_mem_responder;
   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       m_rd = 1'b0, m_wr = 1'b0;
   logic [4:0] m_addr = '0;
   logic [7:0] m_wdata = '0;
   logic [7:0] m_rdata;
   logic       m_rdata_en, m_ready, m_err, m_busy;
   logic [15:0] m_acc_cnt;

   logic       z_rd = 1'b0, z_wr = 1'b0;
   logic [4:0] z_addr = '0;
   logic [7:0] z_wdata = '0;
   logic [7:0] z_rdata;
   logic       z_rdata_en, z_ready, z_err, z_busy;
   logic [15:0] z_acc_cnt;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   mem_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_STATES(2), .PROT_BASE(24)) dut (
      .clk(clk), .rst(rst), .rd(m_rd), .wr(m_wr), .addr(m_addr), .wdata(m_wdata),
      .rdata(m_rdata), .rdata_en(m_rdata_en), .ready(m_ready), .err(m_err),
      .busy(m_busy), .acc_cnt(m_acc_cnt));

   mem_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_STATES(0), .PROT_BASE(24)) dut0 (
      .clk(clk), .rst(rst), .rd(z_rd), .wr(z_wr), .addr(z_addr), .wdata(z_wdata),
      .rdata(z_rdata), .rdata_en(z_rdata_en), .ready(z_ready), .err(z_err),
      .busy(z_busy), .acc_cnt(z_acc_cnt));

   // Drives one request, returns clocks-to-ready (-1 on timeout) and the ACK outputs,
   // then drops the strobes and lets the responder return to IDLE.
   task automatic access(input bit z, input logic r, input logic w, input logic [4:0] a,
                         input logic [7:0] d, output int lat, output logic [7:0] q,
                         output logic q_en, output logic e);
      lat = -1; q = '0; q_en = 1'b0; e = 1'b0;
      if (z) begin z_rd = r; z_wr = w; z_addr = a; z_wdata = d; end
      else   begin m_rd = r; m_wr = w; m_addr = a; m_wdata = d; end
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (z ? z_ready : m_ready) begin
            lat  = i;
            q    = z ? z_rdata : m_rdata;
            q_en = z ? z_rdata_en : m_rdata_en;
            e    = z ? z_err : m_err;
            break;
         end
         // bus wanders after capture; the responder must use its latched copy
         if (z) begin z_addr = a ^ 5'h1F; z_wdata = ~d; end
         else   begin m_addr = a ^ 5'h1F; m_wdata = ~d; end
      end
      if (z) begin z_rd = 1'b0; z_wr = 1'b0; end
      else   begin m_rd = 1'b0; m_wr = 1'b0; end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      int lat; logic [7:0] q; logic q_en, e;
      repeat (3) @(negedge clk);
      checks++; if (m_ready !== 1'b0) $display("FAIL reset_ready got=%b want=0", m_ready); else passed++;
      checks++; if (m_err !== 1'b0) $display("FAIL reset_err got=%b want=0", m_err); else passed++;
      checks++; if (m_busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", m_busy); else passed++;
      checks++; if (m_rdata_en !== 1'b0 || m_rdata !== 8'h00)
         $display("FAIL reset_rdata got=%b/%h want=0/00", m_rdata_en, m_rdata); else passed++;
      checks++; if (m_acc_cnt !== 16'h0) $display("FAIL reset_acc got=%h want=0000", m_acc_cnt); else passed++;
      rst = 1'b1;
      @(negedge clk);
      access(0, 1'b0, 1'b1, 5'd3, 8'h11, lat, q, q_en, e);
      checks++; if (lat !== 3 || e !== 1'b0) $display("FAIL reset_prewrite got lat=%0d err=%b want lat=3 err=0", lat, e); else passed++;
      // write to addr 3 abandoned by reset while in WAIT
      m_wr = 1'b1; m_addr = 5'd3; m_wdata = 8'hEE;
      @(negedge clk);
      checks++; if (m_busy !== 1'b1) $display("FAIL reset_busy_wait got=%b want=1", m_busy); else passed++;
      rst = 1'b0;
      #1;
      checks++; if (m_busy !== 1'b0 || m_ready !== 1'b0 || m_err !== 1'b0)
         $display("FAIL reset_midwait_outs got busy=%b ready=%b err=%b want 0/0/0", m_busy, m_ready, m_err); else passed++;
      checks++; if (m_acc_cnt !== 16'h0) $display("FAIL reset_midwait_acc got=%h want=0000", m_acc_cnt); else passed++;
      m_wr = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      access(0, 1'b1, 1'b0, 5'd3, 8'h00, lat, q, q_en, e);
      checks++; if (q !== 8'h11 || q_en !== 1'b1) $display("FAIL reset_readback got=%h en=%b want=11 en=1", q, q_en); else passed++;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (m_acc_cnt !== 16'h0) $display("FAIL reset_acc2 got=%h want=0000", m_acc_cnt); else passed++;
      rst = 1'b1;
      @(negedge clk);
      $display("test_reset done");
   endtask

   task automatic test_write_read();
      int lat; logic [7:0] q; logic q_en, e;
      access(0, 1'b0, 1'b1, 5'd5, 8'hA7, lat, q, q_en, e);
      checks++; if (lat !== 3) $display("FAIL wr_latency got=%0d want=3", lat); else passed++;
      checks++; if (e !== 1'b0 || q_en !== 1'b0) $display("FAIL wr_ack got err=%b en=%b want 0/0", e, q_en); else passed++;
      access(0, 1'b1, 1'b0, 5'd5, 8'h00, lat, q, q_en, e);
      checks++; if (lat !== 3) $display("FAIL rd_latency got=%0d want=3", lat); else passed++;
      checks++; if (q !== 8'hA7 || q_en !== 1'b1 || e !== 1'b0)
         $display("FAIL rd_data got=%h en=%b err=%b want=a7 1 0", q, q_en, e); else passed++;
      checks++; if (m_acc_cnt !== 16'd2) $display("FAIL wr_rd_acc got=%0d want=2", m_acc_cnt); else passed++;
      checks++; if (m_busy !== 1'b0) $display("FAIL wr_rd_idle got busy=%b want=0", m_busy); else passed++;
      $display("test_write_read done");
   endtask

   task automatic test_protected();
      int lat; logic [7:0] q; logic q_en, e;
      access(0, 1'b0, 1'b1, 5'd26, 8'h3C, lat, q, q_en, e);
      checks++; if (lat !== 3 || e !== 1'b1) $display("FAIL prot_wr got lat=%0d err=%b want lat=3 err=1", lat, e); else passed++;
      access(0, 1'b1, 1'b0, 5'd26, 8'h00, lat, q, q_en, e);
      checks++; if (q === 8'h3C || q_en !== 1'b1 || e !== 1'b0)
         $display("FAIL prot_rd got=%h en=%b err=%b want!=3c 1 0", q, q_en, e); else passed++;
      access(0, 1'b0, 1'b1, 5'd31, 8'h6D, lat, q, q_en, e);
      access(0, 1'b1, 1'b0, 5'd23, 8'h00, lat, q, q_en, e);
      checks++; if (m_acc_cnt !== 16'd6) $display("FAIL prot_acc got=%0d want=6", m_acc_cnt); else passed++;
      access(0, 1'b0, 1'b1, 5'd23, 8'h4B, lat, q, q_en, e);
      checks++; if (e !== 1'b0) $display("FAIL prot_edge23 got err=%b want=0", e); else passed++;
      $display("test_protected done");
   endtask

   task automatic test_conflict();
      int lat; logic [7:0] q; logic q_en, e;
      access(0, 1'b0, 1'b1, 5'd2, 8'h5A, lat, q, q_en, e);
      access(0, 1'b1, 1'b1, 5'd2, 8'hFF, lat, q, q_en, e);
      checks++; if (lat !== 3 || e !== 1'b1) $display("FAIL conflict_err got lat=%0d err=%b want 3 1", lat, e); else passed++;
      checks++; if (q !== 8'h00 || q_en !== 1'b0) $display("FAIL conflict_rdata got=%h en=%b want=00 0", q, q_en); else passed++;
      access(0, 1'b1, 1'b0, 5'd2, 8'h00, lat, q, q_en, e);
      checks++; if (q !== 8'h5A) $display("FAIL conflict_store got=%h want=5a", q); else passed++;
      access(0, 1'b1, 1'b0, 5'd23, 8'h00, lat, q, q_en, e);
      checks++; if (q !== 8'h4B) $display("FAIL rd_addr23 got=%h want=4b", q); else passed++;
      checks++; if (m_acc_cnt !== 16'd11) $display("FAIL conflict_acc got=%0d want=11", m_acc_cnt); else passed++;
      $display("test_conflict done");
   endtask

   task automatic test_hold();
      int lat = -1; int pulses = 0; int busy_low = 0;
      m_rd = 1'b1; m_addr = 5'd5;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (m_ready) begin lat = i; break; end
      end
      checks++; if (lat !== 3 || m_rdata !== 8'hA7) $display("FAIL hold_ack got lat=%0d rdata=%h want 3 a7", lat, m_rdata); else passed++;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (m_ready) pulses++;
         if (!m_busy) busy_low++;
         if (i == 0) begin
            checks++; if (m_rdata_en !== 1'b0 || m_rdata !== 8'h00)
               $display("FAIL hold_rdata got=%h en=%b want=00 0", m_rdata, m_rdata_en); else passed++;
         end
      end
      checks++; if (pulses !== 0) $display("FAIL hold_extra_ready got=%0d want=0", pulses); else passed++;
      checks++; if (busy_low !== 0) $display("FAIL hold_busy got low=%0d want=0", busy_low); else passed++;
      m_rd = 1'b0;
      @(negedge clk);
      checks++; if (m_busy !== 1'b0) $display("FAIL hold_release got busy=%b want=0", m_busy); else passed++;
      checks++; if (m_acc_cnt !== 16'd12) $display("FAIL hold_acc got=%0d want=12", m_acc_cnt); else passed++;
      $display("test_hold done");
   endtask

   task automatic test_zero_wait_saturation();
      int lat; logic [7:0] q; logic q_en, e;
      access(1, 1'b0, 1'b1, 5'd7, 8'hC3, lat, q, q_en, e);
      checks++; if (lat !== 1 || e !== 1'b0) $display("FAIL zw_wr got lat=%0d err=%b want 1 0", lat, e); else passed++;
      force dut0.acc_cnt_reg = 16'hFFFE;
      @(negedge clk);
      release dut0.acc_cnt_reg;
      @(negedge clk);
      checks++; if (z_acc_cnt !== 16'hFFFE) $display("FAIL zw_force got=%h want=fffe", z_acc_cnt); else passed++;
      access(1, 1'b1, 1'b0, 5'd7, 8'h00, lat, q, q_en, e);
      checks++; if (lat !== 1 || q !== 8'hC3 || q_en !== 1'b1)
         $display("FAIL zw_rd1 got lat=%0d q=%h en=%b want 1 c3 1", lat, q, q_en); else passed++;
      checks++; if (z_acc_cnt !== 16'hFFFF) $display("FAIL zw_acc1 got=%h want=ffff", z_acc_cnt); else passed++;
      access(1, 1'b1, 1'b0, 5'd7, 8'h00, lat, q, q_en, e);
      checks++; if (lat !== 1) $display("FAIL zw_rd2 got lat=%0d want 1", lat); else passed++;
      checks++; if (z_acc_cnt !== 16'hFFFF) $display("FAIL zw_acc_sat got=%h want=ffff", z_acc_cnt); else passed++;
      $display("test_zero_wait_saturation done");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_protected();
      test_conflict();
      test_hold();
      test_zero_wait_saturation();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
